// File: rtl/water_level_grader_pkg.sv
// Shared encodings for the water-level grading path.
// The beeper and display stages decode the same grades.
package water_level_grader_pkg;

    localparam logic [2:0] GRADE_SAFE  = 3'd0;
    localparam logic [2:0] GRADE_FAULT = 3'd7;

    localparam int unsigned NumTh = 6;
    localparam int unsigned DefaultTh [NumTh] = '{400, 1000, 1600, 2200, 2800, 3400};

    typedef enum logic [0:0] {
        StTrack,
        StFault
    } fsm_e;

endpackage

// File: rtl/water_level_grader_if.sv
// Sample-in / grade-out bundle between the ADC front-end, the grader and its consumers.
interface water_level_grader_if #(
    parameter int unsigned DW = 12
);
    logic          sample_valid;
    logic [DW-1:0] sample;
    logic [2:0]    state;
    logic          beep_en;
    logic          level_changed;

    modport master (
        output sample_valid, sample,
        input  state, beep_en, level_changed
    );

    modport slave (
        input  sample_valid, sample,
        output state, beep_en, level_changed
    );
endinterface

// File: rtl/water_level_grader_level_quantizer.sv
// Combinational threshold bank: raw grade plus hysteresis-filtered effective grade.
module level_quantizer
    import water_level_grader_pkg::*;
#(
    parameter int unsigned DW   = 12,
    parameter int unsigned TH1  = DefaultTh[0],
    parameter int unsigned TH2  = DefaultTh[1],
    parameter int unsigned TH3  = DefaultTh[2],
    parameter int unsigned TH4  = DefaultTh[3],
    parameter int unsigned TH5  = DefaultTh[4],
    parameter int unsigned TH6  = DefaultTh[5],
    parameter int unsigned HYST = 16
) (
    input  logic [DW-1:0] sample_i,
    input  logic [2:0]    cur_i,
    output logic [2:0]    raw_o,
    output logic [2:0]    eff_o
);
    localparam int unsigned Th [NumTh] = '{TH1, TH2, TH3, TH4, TH5, TH6};

    logic [31:0] s_ext;
    logic        hold;

    assign s_ext = 32'(sample_i);

    always_comb begin
        raw_o = 3'd0;
        hold  = 1'b0;
        for (int k = 0; k < NumTh; k++) begin
            if (s_ext >= Th[k]) raw_o = raw_o + 3'd1;
        end
        // Dropping a grade needs the sample below THc - HYST, not merely below THc.
        if (cur_i >= 3'd1 && cur_i <= 3'd6) begin
            hold = s_ext >= (Th[cur_i - 3'd1] - HYST);
        end
        eff_o = (raw_o >= cur_i || !hold) ? raw_o : cur_i;
    end
endmodule

// File: rtl/water_level_grader.sv
// Debounced water-level grade with hysteresis and sensor-fault detection (grade 7).
module water_level_grader
    import water_level_grader_pkg::*;
#(
    parameter int unsigned DW         = 12,
    parameter int unsigned TH1        = DefaultTh[0],
    parameter int unsigned TH2        = DefaultTh[1],
    parameter int unsigned TH3        = DefaultTh[2],
    parameter int unsigned TH4        = DefaultTh[3],
    parameter int unsigned TH5        = DefaultTh[4],
    parameter int unsigned TH6        = DefaultTh[5],
    parameter int unsigned HYST       = 16,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned FAULT_CNT  = 8,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input logic                clk,
    input logic                rst,
    water_level_grader_if.slave bus
);
    localparam int unsigned CntW = $clog2(STABLE_CNT + 1);
    localparam int unsigned SatW = $clog2(FAULT_CNT + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

    fsm_e            fsm_q, fsm_d;
    logic [2:0]      state_q, state_d;
    logic [2:0]      cand_q, cand_d;
    logic            beep_q, beep_d;
    logic            lc_q, lc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SatW-1:0] sat_q, sat_d;
    logic [ToW-1:0]  to_q, to_d;

    logic [2:0] raw, eff;
    logic       is_sat, good, sat_hit, to_hit;

    level_quantizer #(
        .DW(DW), .TH1(TH1), .TH2(TH2), .TH3(TH3), .TH4(TH4), .TH5(TH5), .TH6(TH6), .HYST(HYST)
    ) u_quant (
        .sample_i (bus.sample),
        .cur_i    (state_q),
        .raw_o    (raw),
        .eff_o    (eff)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        to_d    = to_q;

        is_sat = bus.sample_valid && (bus.sample == {DW{1'b1}});
        good   = bus.sample_valid && !is_sat;

        if (bus.sample_valid)            to_d = '0;
        else if (to_q != ToW'(TIMEOUT))  to_d = to_q + ToW'(1);

        if (is_sat) begin
            if (sat_q != SatW'(FAULT_CNT)) sat_d = sat_q + SatW'(1);
        end else if (bus.sample_valid) begin
            sat_d = '0;
        end

        to_hit  = !bus.sample_valid && (to_d == ToW'(TIMEOUT));
        sat_hit = is_sat && (sat_d == SatW'(FAULT_CNT));

        unique case (fsm_q)
            StTrack: begin
                if (sat_hit || to_hit) begin
                    fsm_d   = StFault;
                    state_d = GRADE_FAULT;
                    cnt_d   = '0;
                    cand_d  = GRADE_SAFE;
                end else if (good) begin
                    if (eff == state_q) begin
                        cnt_d = '0;
                    end else begin
                        if (eff != cand_q) begin
                            cand_d = eff;
                            cnt_d  = CntW'(1);
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                        if (cnt_d == CntW'(STABLE_CNT)) begin
                            state_d = cand_d;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            StFault: begin
                // Recovery needs an unbroken run of clean samples; raw grade, no hysteresis.
                if (is_sat || to_hit) begin
                    cnt_d = '0;
                end else if (good) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_d == CntW'(STABLE_CNT)) begin
                        fsm_d   = StTrack;
                        state_d = raw;
                        cnt_d   = '0;
                        cand_d  = GRADE_SAFE;
                        sat_d   = '0;
                        to_d    = '0;
                    end
                end
            end
            default: fsm_d = StTrack;
        endcase

        beep_d = (state_d != GRADE_SAFE);
        lc_d   = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= StTrack;
            state_q <= GRADE_SAFE;
            cand_q  <= GRADE_SAFE;
            beep_q  <= 1'b0;
            lc_q    <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= '0;
            to_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cand_q  <= cand_d;
            beep_q  <= beep_d;
            lc_q    <= lc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            to_q    <= to_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.beep_en       = beep_q;
    assign bus.level_changed = lc_q;
endmodule

// File: tb/tb_water_level_grader.sv
// Scenario bench for water_level_grader with a per-cycle behavioural reference model.
module tb_water_level_grader;
    localparam int Timeout = 50;
    localparam int Stable  = 4;
    localparam int FaultN  = 8;
    localparam int Hyst    = 16;
    localparam int Full    = 4095;
    localparam int Th [6]  = '{400, 1000, 1600, 2200, 2800, 3400};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    water_level_grader_if #(.DW(12)) bus ();

    water_level_grader #(.TIMEOUT(Timeout)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    typedef struct packed {
        int   grade;
        int   cand;
        int   cnt;
        int   sat;
        int   idle;
        logic fault;
        logic changed;
    } model_t;

    model_t m = '0;

    function automatic model_t model_next(model_t p, logic r, logic v, int s);
        model_t n = p;
        int raw = 0;
        int eff;
        bit sat, sat_hit, to_hit;
        n.changed = 1'b0;
        if (r) return '0;
        foreach (Th[k]) if (s >= Th[k]) raw++;
        sat = v && (s == Full);
        n.idle = v ? 0 : ((p.idle < Timeout) ? p.idle + 1 : p.idle);
        if (sat) n.sat = (p.sat < FaultN) ? p.sat + 1 : p.sat;
        else if (v) n.sat = 0;
        to_hit  = !v && (n.idle == Timeout);
        sat_hit = sat && (n.sat == FaultN);
        if (!p.fault) begin
            if (sat_hit || to_hit) begin
                n.fault = 1'b1; n.grade = 7; n.cnt = 0; n.cand = 0;
            end else if (v && !sat) begin
                if (raw >= p.grade) eff = raw;
                else if (p.grade > 0 && s >= Th[p.grade-1] - Hyst) eff = p.grade;
                else eff = raw;
                if (eff == p.grade) n.cnt = 0;
                else begin
                    if (eff != p.cand) begin n.cand = eff; n.cnt = 1; end
                    else n.cnt = p.cnt + 1;
                    if (n.cnt == Stable) begin n.grade = n.cand; n.cnt = 0; end
                end
            end
        end else begin
            if (sat || to_hit) n.cnt = 0;
            else if (v) begin
                n.cnt = p.cnt + 1;
                if (n.cnt == Stable) begin
                    n.grade = raw; n.fault = 1'b0; n.cnt = 0; n.cand = 0; n.sat = 0; n.idle = 0;
                end
            end
        end
        n.changed = (n.grade != p.grade);
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m, rst, bus.sample_valid, int'(bus.sample));

    always @(negedge clk) if (bus.level_changed === 1'b1) pulses <= pulses + 1;

    task automatic send(input int v);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample       = 12'(v);
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset(3);
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        n_checks++; if (bus.beep_en !== 1'b0) begin n_fail++; $display("FAIL reset_beep got=%b exp=0", bus.beep_en); end
        n_checks++; if (bus.level_changed !== 1'b0) begin n_fail++; $display("FAIL reset_lc got=%b exp=0", bus.level_changed); end
    endtask

    task automatic test_rise();
        int p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            send(1700);
            n_checks++; if (bus.state !== ((i < 3) ? 3'd0 : 3'd3)) begin n_fail++; $display("FAIL rise_state[%0d] got=%0d exp=%0d", i, bus.state, (i < 3) ? 0 : 3); end
        end
        n_checks++; if (bus.beep_en !== 1'b1) begin n_fail++; $display("FAIL rise_beep got=%b exp=1", bus.beep_en); end
        n_checks++; if (bus.level_changed !== 1'b1) begin n_fail++; $display("FAIL rise_lc got=%b exp=1", bus.level_changed); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL rise_pulses got=%0d exp=1", pulses - p0); end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 4; i++) begin
            send(1590);
            n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL hyst_hold[%0d] got=%0d exp=3", i, bus.state); end
        end
        for (int i = 0; i < 4; i++) begin
            send(1500);
            n_checks++; if (bus.state !== ((i < 3) ? 3'd3 : 3'd2)) begin n_fail++; $display("FAIL hyst_drop[%0d] got=%0d exp=%0d", i, bus.state, (i < 3) ? 3 : 2); end
        end
    endtask

    task automatic test_debounce_reset();
        int seq [8] = '{1700, 1700, 1700, 300, 1700, 1700, 1700, 1700};
        pulse_reset(1);
        foreach (seq[i]) begin
            send(seq[i]);
            n_checks++; if (bus.state !== ((i < 7) ? 3'd0 : 3'd3)) begin n_fail++; $display("FAIL deb_state[%0d] got=%0d exp=%0d", i, bus.state, (i < 7) ? 0 : 3); end
        end
    endtask

    task automatic test_saturation_fault();
        for (int i = 0; i < 8; i++) begin
            send(Full);
            n_checks++; if (bus.state !== ((i < 7) ? 3'd3 : 3'd7)) begin n_fail++; $display("FAIL sat_state[%0d] got=%0d exp=%0d", i, bus.state, (i < 7) ? 3 : 7); end
        end
        n_checks++; if (bus.level_changed !== 1'b1) begin n_fail++; $display("FAIL sat_lc got=%b exp=1", bus.level_changed); end
        for (int i = 0; i < 4; i++) begin
            send(2300);
            n_checks++; if (bus.state !== ((i < 3) ? 3'd7 : 3'd4)) begin n_fail++; $display("FAIL sat_recover[%0d] got=%0d exp=%0d", i, bus.state, (i < 3) ? 7 : 4); end
        end
        // Hysteresis hold only applies when tracking again.
        for (int i = 0; i < 4; i++) send(2190);
        n_checks++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL sat_track got=%0d exp=4", bus.state); end
    endtask

    task automatic test_timeout_fault();
        repeat (Timeout - 1) @(posedge clk);
        #1;
        n_checks++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL to_early got=%0d exp=4", bus.state); end
        @(posedge clk);
        #1;
        n_checks++; if (bus.state !== 3'd7) begin n_fail++; $display("FAIL to_fault got=%0d exp=7", bus.state); end
        n_checks++; if (bus.level_changed !== 1'b1) begin n_fail++; $display("FAIL to_lc got=%b exp=1", bus.level_changed); end
        for (int i = 0; i < 3; i++) send(500);
        send(Full);
        n_checks++; if (bus.state !== 3'd7) begin n_fail++; $display("FAIL to_satbreak got=%0d exp=7", bus.state); end
        for (int i = 0; i < 4; i++) begin
            send(500);
            n_checks++; if (bus.state !== ((i < 3) ? 3'd7 : 3'd1)) begin n_fail++; $display("FAIL to_recover[%0d] got=%0d exp=%0d", i, bus.state, (i < 3) ? 7 : 1); end
        end
    endtask

    task automatic test_reset_midway();
        pulse_reset(1);
        for (int i = 0; i < 4; i++) send(3000);
        n_checks++; if (bus.state !== 3'd5) begin n_fail++; $display("FAIL mid_state5 got=%0d exp=5", bus.state); end
        send(3500);
        send(3500);
        pulse_reset(1);
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL mid_state got=%0d exp=0", bus.state); end
        n_checks++; if (bus.beep_en !== 1'b0) begin n_fail++; $display("FAIL mid_beep got=%b exp=0", bus.beep_en); end
        n_checks++; if (bus.level_changed !== 1'b0) begin n_fail++; $display("FAIL mid_lc got=%b exp=0", bus.level_changed); end
        for (int i = 0; i < 4; i++) begin
            send(3500);
            n_checks++; if (bus.state !== ((i < 3) ? 3'd0 : 3'd6)) begin n_fail++; $display("FAIL mid_cleared[%0d] got=%0d exp=%0d", i, bus.state, (i < 3) ? 0 : 6); end
        end
    endtask

    task automatic test_random();
        int v;
        pulse_reset(1);
        for (int n = 0; n < 300; n++) begin
            int r = $urandom_range(0, 9);
            if ($urandom_range(0, 49) == 0) repeat (Timeout + 5) @(posedge clk);
            if (r == 0) v = Full;
            else if (r == 9) v = $urandom_range(0, Full - 1);
            else v = Th[$urandom_range(0, 5)] + $urandom_range(0, 40) - 20;
            for (int b = 0; b < ((r == 0) ? $urandom_range(1, 9) : 1); b++) begin
                send(v);
                n_checks++; if (int'(bus.state) !== m.grade) begin n_fail++; $display("FAIL rnd_state[%0d] got=%0d exp=%0d", n, bus.state, m.grade); end
                n_checks++; if (bus.beep_en !== (m.grade != 0)) begin n_fail++; $display("FAIL rnd_beep[%0d] got=%b exp=%b", n, bus.beep_en, m.grade != 0); end
                n_checks++; if (bus.level_changed !== m.changed) begin n_fail++; $display("FAIL rnd_lc[%0d] got=%b exp=%b", n, bus.level_changed, m.changed); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        test_reset();
        test_rise();
        test_hysteresis();
        test_debounce_reset();
        test_saturation_fault();
        test_timeout_fault();
        test_reset_midway();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/water_level_grader.md
Name: water_level_grader

Overview:
- Upstream of the buzzer stage. Converts raw water-level ADC samples into the 3-bit alarm grade (`state`) and the `beep_en` flag that the beeper consumes.
- Grades 0..6 come from six ascending thresholds. Downward moves are filtered by hysteresis, and every grade change is debounced.
- Grade 7 is reserved for sensor fault: a saturated reading or a missing-sample timeout.
- Sits between the ADC sampling front-end and the beep/display stages.

Parameters:
- DW, 12, sample width in bits.
- TH1..TH6, 400/1000/1600/2200/2800/3400, ascending grade thresholds in ADC codes. Require TH1 < TH2 < ... < TH6 < 2^DW-1.
- HYST, 16, downward hysteresis margin in ADC codes. Require HYST < TH1.
- STABLE_CNT, 4, consecutive valid samples needed to commit a new grade or to leave fault.
- FAULT_CNT, 8, consecutive saturated samples (all ones) that force fault.
- TIMEOUT, 1000000, clk cycles without `sample_valid` that force fault.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe; `sample` is valid this cycle.
- sample  in  DW  ADC level code.
- state  out  3  committed grade: 0 = dry/safe, 1..6 = rising alarm level, 7 = sensor fault.
- beep_en  out  1  equals (state != 0), registered together with `state`.
- level_changed  out  1  one-cycle pulse on the cycle `state` takes a new value.

Behaviour:
- Reset (rst=1 at a clk edge): state=0, beep_en=0, level_changed=0. Candidate, debounce, saturation and timeout counters all clear to 0. FSM enters TRACK. Reset mid-operation aborts any pending commit.
- raw = number of k in 1..6 with sample >= THk, giving 0..6.
- Effective grade eff, with current grade c (TRACK only):
  - if raw >= c: eff = raw;
  - else if c > 0 and sample >= THc - HYST: eff = c (hold);
  - else: eff = raw.
- Debounce (TRACK), evaluated on each sample_valid with a non-saturated sample:
  - eff == state: clear the counter.
  - eff != cand: cand = eff, cnt = 1.
  - otherwise: cnt++.
  - When cnt reaches STABLE_CNT, commit state = cand and clear cnt.
  - Multi-grade jumps commit directly; no stepping through intermediate grades.
- Latency: the new `state`, `beep_en` and `level_changed` pulse are visible the cycle after the clk edge that accepts the STABLE_CNT-th qualifying sample.
- Saturation: a sample == 2^DW-1 increments the saturation counter and does not touch debounce. Any non-saturated valid sample clears it. Reaching FAULT_CNT means go to FAULT.
- Timeout: the counter increments every cycle without sample_valid and clears on sample_valid. Reaching TIMEOUT means go to FAULT. If saturation and timeout hit in the same cycle, the result is a single FAULT entry.
- FSM states:
  - TRACK: normal grading as above.
  - FAULT: state=7 (with a level_changed pulse on entry). Debounce counts consecutive valid non-saturated samples. Any saturated sample or timeout restarts that count. At STABLE_CNT, commit state = raw (no hysteresis), pulse level_changed, return to TRACK with counters cleared.
- Counter widths: counters saturate at their terminal value and must not wrap.
- sample_valid with rst=1 is ignored.

Decomposition:
- Shared package holds:
  - grade constants GRADE_SAFE=3'd0 and GRADE_FAULT=3'd7 (the beeper decodes the same encoding);
  - FSM enum {TRACK, FAULT};
  - a default threshold array.
- One natural sub-module: `level_quantizer`, a combinational sample-to-raw-grade comparator bank plus the hysteresis hold compare. It is reusable by the display stage.

Test Plan:
- After reset, send 4 valid samples of 1700 -> state goes 0→3 after the 4th sample, beep_en=1, one level_changed pulse. Before that, state stays 0.
- From state 3, send samples 1590,1590,1590,1590 (inside the hysteresis band, above 1584) -> state stays 3. Then send 4×1500 -> state=2.
- Debounce reset: from state 0, send 1700,1700,1700,300,1700,1700,1700,1700 -> no change until the 8th sample, then state=3.
- Send 8 consecutive samples of 4095 -> state=7 on the 8th, with a pulse. Then send 4×2300 -> state=4 and the FSM is back in TRACK.
- With TIMEOUT overridden to 50, hold sample_valid low for 50 cycles -> state=7. Then send 3 valid samples of 500 and 1 of 4095, then 4 of 500 -> state=1 only after the final 4.
- Assert rst for one cycle while in state 5 with 2 samples pending -> next cycle state=0, beep_en=0, no level_changed pulse, and all counters cleared.
